// File: rtl/cla_seq_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead add/subtract sequencer.
package cla_seq_add_ctrl_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_seq_add_ctrl_cla.sv
// 4-bit carry-lookahead adder (the team CLA_adder): generate/propagate with
// fully expanded carries so no carry ripples inside the nibble.
module cla_seq_add_ctrl_cla (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];

endmodule

// File: rtl/cla_seq_add_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit CLA reused over the operand
// nibbles, LSB first, with the nibble carry held in a register between passes.
module cla_seq_add_ctrl
    import cla_seq_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int NUM_NIB = WIDTH / NIBBLE;
    localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NIB - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready only in IDLE, out_valid only in DONE.
    state_t             r_state;
    logic [CNT_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;

    logic [NIBBLE-1:0]  w_a_nib;
    logic [NIBBLE-1:0]  w_b_nib;
    logic [NIBBLE-1:0]  w_sum;
    logic               w_cout;

    assign w_a_nib = r_a[NIBBLE*int'(r_idx) +: NIBBLE];
    assign w_b_nib = r_b[NIBBLE*int'(r_idx) +: NIBBLE];

    cla_seq_add_ctrl_cla u_cla_adder (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1: invert B and seed the carry.
                        r_a     <= op_a;
                        r_b     <= op_sub ? ~op_b : op_b;
                        r_carry <= op_sub;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result[NIBBLE*int'(r_idx) +: NIBBLE] <= w_sum;
                    r_carry <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_carry_out <= w_cout;
                        // MSB operand bits xor sum bit give the carry into the MSB.
                        r_overflow  <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum[NIBBLE-1] ^ w_cout;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Directed bench for cla_seq_add_ctrl (WIDTH=16): latency, add/sub flags,
// backpressure, operand stability and mid-run reset.
module tb_cla_seq_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry_out;
    logic        overflow;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    cla_seq_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Called at a negedge; returns at a negedge.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [15:0] er, input logic ec, input logic ev,
                         input string name, input bit release_now, input bit scramble);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: in_ready=%0b required 1", name, in_ready);
        end
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (dbg_state !== 2'd1) begin
            n_fail++;
            $display("FAIL %s run_state: state=%0d required 1", name, dbg_state);
        end
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) @(negedge clk);
            if (scramble) begin
                op_a = 16'($urandom_range(0, 65535));
                op_b = 16'($urandom_range(0, 65535));
                op_sub = 1'($urandom_range(0, 1));
            end
            n_checks++;
            if (out_valid !== (i == 5) || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s latency cycle %0d: out_valid=%0b in_ready=%0b required %0b 0",
                         name, i, out_valid, in_ready, (i == 5));
            end
        end
        n_checks++;
        if (result !== er) begin
            n_fail++;
            $display("FAIL %s result: got %h required %h", name, result, er);
        end
        n_checks++;
        if (carry_out !== ec || overflow !== ev) begin
            n_fail++;
            $display("FAIL %s flags: carry=%0b ovf=%0b required %0b %0b",
                     name, carry_out, overflow, ec, ev);
        end
        if (release_now) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== er) begin
                n_fail++;
                $display("FAIL %s handoff: out_valid=%0b in_ready=%0b result=%h required 0 1 %h",
                         name, out_valid, in_ready, result, er);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_sub = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 16'h0 ||
            carry_out !== 1'b0 || overflow !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold: rdy=%0b ov=%0b res=%h c=%0b v=%0b st=%0d required 0 0 0000 0 0 0",
                     in_ready, out_valid, result, carry_out, overflow, dbg_state);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_add();
        do_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, "add_basic", 1'b1, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ripple", 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf", 1'b1, 1'b0);
    endtask

    task automatic test_sub();
        do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf", 1'b1, 1'b0);
        do_op(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow", 1'b1, 1'b0);
        do_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_equal", 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_op(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, "bp_op", 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            in_valid = (k % 2 == 0);
            op_a = 16'h0100 + 16'(k);
            op_b = 16'h0001;
            op_sub = 1'b0;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'hFFFF ||
                carry_out !== 1'b0 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: ov=%0b rdy=%0b res=%h c=%0b v=%0b required 1 0 ffff 0 0",
                         k, out_valid, in_ready, result, carry_out, overflow);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_release: ov=%0b rdy=%0b st=%0d required 0 1 0",
                     out_valid, in_ready, dbg_state);
        end
        do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, "back_to_back", 1'b1, 1'b0);
    endtask

    task automatic test_operand_change();
        do_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, "operand_change", 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst accept: in_ready=%0b required 1", in_ready);
        end
        op_a = 16'h4444; op_b = 16'h4444; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0 ||
            carry_out !== 1'b0 || overflow !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst state: rdy=%0b ov=%0b res=%h c=%0b v=%0b st=%0d required 1 0 0000 0 0 0",
                     in_ready, out_valid, result, carry_out, overflow, dbg_state);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst no_valid cycle %0d: out_valid=%0b required 0", i, out_valid);
            end
        end
        do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "after_rst", 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_operand_change();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
